twiddle_mult_radix2_2: RTL

Streaming twiddle-multiply stage for the 16-point radix-2^2 single-delay-feedback FFT. It sits between the first BF2I/BF2II butterfly pair and the second. It tracks the sample index within each 16-sample frame and computes the twiddle exponent. It drives the exponent as the address of the combinational Q15 twiddle ROM, then multiplies each complex sample by the returned W_16^k with rounding and saturation. The block is the address-generating, data-consuming end of the twiddle ROM interface.

---
 rtl/twiddle_mult_radix2_2.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/twiddle_mult_radix2_2.sv
// Twiddle-multiply stage between the two butterfly pairs of a 16-point
// radix-2^2 SDF FFT: generates ROM address, multiplies by W_16^k in Q15.
module twiddle_mult_radix2_2 #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic signed [WIDTH-1:0] in_real,
  input  logic signed [WIDTH-1:0] in_imag,
  output logic [3:0]              tw_addr,
  input  logic signed [WIDTH-1:0] tw_real,
  input  logic signed [WIDTH-1:0] tw_imag,
  output logic                    out_valid,
  output logic                    out_sop,
  output logic signed [WIDTH-1:0] out_real,
  output logic signed [WIDTH-1:0] out_imag,
  output logic                    out_ovf
);

  localparam int PW = 2 * WIDTH;

  localparam logic signed [PW:0] RND =
    {{(WIDTH+2){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};
  localparam logic signed [PW:0] MAXV =
    {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW:0] MINV =
    {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAXQ =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINQ =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [3:0] r_idx;
  logic [3:0] w_cur;
  logic [1:0] w_g;
  logic [1:0] w_m;
  logic [1:0] w_br;
  logic [3:0] w_k;
  logic       w_acc;

  logic signed [WIDTH-1:0] r1_a, r1_b, r1_c, r1_d;
  logic                    r1_v, r1_sop, r1_byp;

  logic signed [PW-1:0]    r2_ac, r2_bd, r2_ad, r2_bc;
  logic signed [WIDTH-1:0] r2_a, r2_b;
  logic                    r2_v, r2_sop, r2_byp;

  logic signed [PW:0]      w_re, w_im;
  logic signed [PW:0]      w_re_rd, w_im_rd;
  logic signed [WIDTH-1:0] w_re_sat, w_im_sat;
  logic                    w_re_ovf, w_im_ovf;

  assign w_acc = in_valid && in_sop;

  // Index of the current sample and its twiddle exponent k = m * br(g)
  always_comb begin
    w_cur = w_acc ? 4'd0 : r_idx;
    w_g   = w_cur[3:2];
    w_m   = w_cur[1:0];
    w_br  = {w_g[0], w_g[1]};
    w_k   = {2'b00, w_m} * {2'b00, w_br};
  end

  assign tw_addr = in_valid ? w_k : 4'd0;

  // Sample index counter: sop restarts at 1, plain valid increments
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= 4'd0;
    end else if (in_valid) begin
      r_idx <= w_acc ? 4'd1 : r_idx + 4'd1;
    end
  end

  // S1: capture operands, twiddle and sideband
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_a   <= '0;
      r1_b   <= '0;
      r1_c   <= '0;
      r1_d   <= '0;
      r1_v   <= 1'b0;
      r1_sop <= 1'b0;
      r1_byp <= 1'b0;
    end else begin
      r1_a   <= in_real;
      r1_b   <= in_imag;
      r1_c   <= tw_real;
      r1_d   <= tw_imag;
      r1_v   <= in_valid;
      r1_sop <= w_acc;
      r1_byp <= (tw_addr == 4'd0);
    end
  end

  // S2: the four partial products
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r2_ac  <= '0;
      r2_bd  <= '0;
      r2_ad  <= '0;
      r2_bc  <= '0;
      r2_a   <= '0;
      r2_b   <= '0;
      r2_v   <= 1'b0;
      r2_sop <= 1'b0;
      r2_byp <= 1'b0;
    end else begin
      r2_ac  <= PW'(r1_a) * PW'(r1_c);
      r2_bd  <= PW'(r1_b) * PW'(r1_d);
      r2_ad  <= PW'(r1_a) * PW'(r1_d);
      r2_bc  <= PW'(r1_b) * PW'(r1_c);
      r2_a   <= r1_a;
      r2_b   <= r1_b;
      r2_v   <= r1_v;
      r2_sop <= r1_sop;
      r2_byp <= r1_byp;
    end
  end

  // Complex sum, round half up, saturate to Q15
  always_comb begin
    w_re    = (PW+1)'(r2_ac) - (PW+1)'(r2_bd);
    w_im    = (PW+1)'(r2_ad) + (PW+1)'(r2_bc);
    w_re_rd = (w_re + RND) >>> (WIDTH - 1);
    w_im_rd = (w_im + RND) >>> (WIDTH - 1);
    w_re_ovf = (w_re_rd > MAXV) || (w_re_rd < MINV);
    w_im_ovf = (w_im_rd > MAXV) || (w_im_rd < MINV);
    if (w_re_rd > MAXV)      w_re_sat = MAXQ;
    else if (w_re_rd < MINV) w_re_sat = MINQ;
    else                     w_re_sat = w_re_rd[WIDTH-1:0];
    if (w_im_rd > MAXV)      w_im_sat = MAXQ;
    else if (w_im_rd < MINV) w_im_sat = MINQ;
    else                     w_im_sat = w_im_rd[WIDTH-1:0];
  end

  // S3: output registers, k = 0 passes the sample through untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= r2_v;
      out_sop   <= r2_sop;
      out_real  <= r2_byp ? r2_a : w_re_sat;
      out_imag  <= r2_byp ? r2_b : w_im_sat;
      out_ovf   <= r2_v && !r2_byp && (w_re_ovf || w_im_ovf);
    end
  end

endmodule
